// File: rtl/rca_ctrl_pkg.sv
// Shared definitions for the nibble-serial adder controller: slice width,
// FSM state encoding and the counter-width helper.
package rca_ctrl_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // A single-nibble build still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rca_4bit.sv
// 4-bit ripple-carry adder slice, purely combinational; reused by the
// serial controller once per nibble.
module rca_4bit
  import rca_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] X,
  input  logic [NIB_W-1:0] Y,
  input  logic             C_IN,
  output logic [NIB_W-1:0] SUM,
  output logic             C_OUT
);

  logic [NIB_W:0] carry;

  assign carry[0] = C_IN;

  generate
    for (genvar gi = 0; gi < NIB_W; gi++) begin : g_fa
      assign SUM[gi]      = X[gi] ^ Y[gi] ^ carry[gi];
      assign carry[gi+1]  = (X[gi] & Y[gi]) | (carry[gi] & (X[gi] ^ Y[gi]));
    end
  endgenerate

  assign C_OUT = carry[NIB_W];

endmodule

// File: rtl/rca_serial_ctrl.sv
// Nibble-serial wide adder/subtractor with START/BUSY/DONE handshake.
// Define RCA_SERIAL_ACC_EN to add the ACC port (operand A taken from SUM).
module rca_serial_ctrl
  import rca_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic                     SUB,
  input  logic [NIB_W*NIBBLES-1:0] X,
  input  logic [NIB_W*NIBBLES-1:0] Y,
  input  logic                     C_IN,
`ifdef RCA_SERIAL_ACC_EN
  input  logic                     ACC,
`endif
  output logic                     BUSY,
  output logic                     DONE,
  output logic [NIB_W*NIBBLES-1:0] SUM,
  output logic                     C_OUT,
  output logic                     OVF
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int CNT_W = cnt_width(NIBBLES);

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic [W-1:0]       res_reg;
  logic               carry_reg;
  logic [W-1:0]       sum_reg;
  logic               c_out_reg;
  logic               ovf_reg;
  logic               done_reg;

  logic [W-1:0]       a_src;
  logic [W-1:0]       res_next;
  logic [NIB_W-1:0]   slice_x;
  logic [NIB_W-1:0]   slice_y;
  logic [NIB_W-1:0]   slice_sum;
  logic               slice_cout;
  logic               last_nib;

`ifdef RCA_SERIAL_ACC_EN
  assign a_src = ACC ? sum_reg : X;
`else
  assign a_src = X;
`endif

  assign slice_x  = a_reg[cnt_reg*NIB_W +: NIB_W];
  assign slice_y  = b_reg[cnt_reg*NIB_W +: NIB_W];
  assign last_nib = (cnt_reg == CNT_W'(NIBBLES - 1));

  rca_4bit u_slice (
    .X     (slice_x),
    .Y     (slice_y),
    .C_IN  (carry_reg),
    .SUM   (slice_sum),
    .C_OUT (slice_cout)
  );

  // Result with the current nibble merged in, so the final nibble can be
  // published to SUM on the same edge it is computed.
  generate
    for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_res
      assign res_next[gi*NIB_W +: NIB_W] =
        (cnt_reg == CNT_W'(gi)) ? slice_sum : res_reg[gi*NIB_W +: NIB_W];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (START) begin
            a_reg     <= a_src;
            b_reg     <= SUB ? ~Y : Y;
            carry_reg <= SUB ? 1'b1 : C_IN;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
        end
        RUN: begin
          res_reg   <= res_next;
          carry_reg <= slice_cout;
          if (last_nib) begin
            cnt_reg   <= '0;
            sum_reg   <= res_next;
            c_out_reg <= slice_cout;
            ovf_reg   <= (a_reg[W-1] == b_reg[W-1]) && (res_next[W-1] != a_reg[W-1]);
            done_reg  <= 1'b1;
            state_reg <= FIN;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        FIN: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign BUSY  = (state_reg == RUN);
  assign DONE  = done_reg;
  assign SUM   = sum_reg;
  assign C_OUT = c_out_reg;
  assign OVF   = ovf_reg;

endmodule

// File: tb/tb_rca_serial_ctrl.sv
// Self-checking bench for rca_serial_ctrl: directed vectors, handshake cases
// and randomized operations checked against an arithmetic reference model.
module tb_rca_serial_ctrl;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic         CLK = 1'b0;
  logic         RST;
  logic         START;
  logic         SUB;
  logic         C_IN;
  logic [W-1:0] X;
  logic [W-1:0] Y;
`ifdef RCA_SERIAL_ACC_EN
  logic         ACC;
`endif
  logic         BUSY;
  logic         DONE;
  logic [W-1:0] SUM;
  logic         C_OUT;
  logic         OVF;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model_sum;

  always #5 CLK = ~CLK;

  rca_serial_ctrl #(.NIBBLES(NIBBLES)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .START (START),
    .SUB   (SUB),
    .X     (X),
    .Y     (Y),
    .C_IN  (C_IN),
`ifdef RCA_SERIAL_ACC_EN
    .ACC   (ACC),
`endif
    .BUSY  (BUSY),
    .DONE  (DONE),
    .SUM   (SUM),
    .C_OUT (C_OUT),
    .OVF   (OVF)
  );

  // Returns {ovf, carry, sum} from plain wide and signed arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] y,
                                         input logic cin, input logic sub);
    logic [W:0] full;
    longint     exact;
    longint     lim;
    if (sub) full = {1'b0, a} + {1'b0, ~y} + (W+1)'(1);
    else     full = {1'b0, a} + {1'b0, y} + {{W{1'b0}}, cin};
    if (sub) exact = longint'($signed(a)) - longint'($signed(y));
    else     exact = longint'($signed(a)) + longint'($signed(y)) + longint'(cin);
    lim = longint'(1) <<< (W - 1);
    return {((exact >= lim) || (exact < -lim)), full[W], full[W-1:0]};
  endfunction

  // Issues one START and waits (bounded) for DONE; cycle 1 is the cycle after the START edge.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin,
                        input logic sub, output logic [W-1:0] s, output logic co,
                        output logic ov, output int busy_cnt, output int done_cyc);
    @(negedge CLK);
    X = x; Y = y; C_IN = cin; SUB = sub; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    busy_cnt = 0;
    done_cyc = 0;
    for (int c = 1; c <= NIBBLES + 6 && done_cyc == 0; c++) begin
      if (c > 1) @(negedge CLK);
      if (BUSY) busy_cnt++;
      if (DONE) done_cyc = c;
    end
    s = SUM; co = C_OUT; ov = OVF;
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; SUB = 1'b0; C_IN = 1'b0; X = '0; Y = '0;
`ifdef RCA_SERIAL_ACC_EN
    ACC = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    checks += 5;
    if (SUM !== '0)     begin errors++; $display("FAIL reset_sum got=%h exp=0", SUM); end
    if (C_OUT !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", C_OUT); end
    if (OVF !== 1'b0)   begin errors++; $display("FAIL reset_ovf got=%b exp=0", OVF); end
    if (BUSY !== 1'b0)  begin errors++; $display("FAIL reset_busy got=%b exp=0", BUSY); end
    if (DONE !== 1'b0)  begin errors++; $display("FAIL reset_done got=%b exp=0", DONE); end
    RST = 1'b0;
    model_sum = '0;
  endtask

  task automatic test_directed();
    logic [W-1:0] vx[5]   = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h0003};
    logic [W-1:0] vy[5]   = '{16'h0FCC, 16'h0001, 16'h0001, 16'h0001, 16'h0005};
    logic         vc[5]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic         vsub[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W-1:0] es[5]   = '{16'h2200, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE};
    logic         ec[5]   = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic         eo[5]   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] s;
    logic         co, ov;
    int           bc, dc;
`ifdef RCA_SERIAL_ACC_EN
    ACC = 1'b0;
`endif
    for (int i = 0; i < 5; i++) begin
      run_op(vx[i], vy[i], vc[i], vsub[i], s, co, ov, bc, dc);
      $display("directed[%0d] x=%h y=%h sub=%b -> sum=%h c=%b ovf=%b busy=%0d done@%0d",
               i, vx[i], vy[i], vsub[i], s, co, ov, bc, dc);
      checks += 5;
      if (s !== es[i])       begin errors++; $display("FAIL dir_sum[%0d] got=%h exp=%h", i, s, es[i]); end
      if (co !== ec[i])      begin errors++; $display("FAIL dir_cout[%0d] got=%b exp=%b", i, co, ec[i]); end
      if (ov !== eo[i])      begin errors++; $display("FAIL dir_ovf[%0d] got=%b exp=%b", i, ov, eo[i]); end
      if (bc != NIBBLES)     begin errors++; $display("FAIL dir_busy_cycles[%0d] got=%0d exp=%0d", i, bc, NIBBLES); end
      if (dc != NIBBLES + 1) begin errors++; $display("FAIL dir_done_cycle[%0d] got=%0d exp=%0d", i, dc, NIBBLES + 1); end
      model_sum = es[i];
    end
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, a, s;
    logic         cin, sub, co, ov;
    logic [W+1:0] exp_v;
    int           bc, dc;
    for (int i = 0; i < 25; i++) begin
      x = W'($urandom); y = W'($urandom);
      cin = 1'($urandom); sub = 1'($urandom);
      a = x;
`ifdef RCA_SERIAL_ACC_EN
      ACC = 1'($urandom_range(0, 3) == 0);
      if (ACC) a = model_sum;
`endif
      exp_v = model(a, y, cin, sub);
      run_op(x, y, cin, sub, s, co, ov, bc, dc);
      $display("random[%0d] a=%h y=%h cin=%b sub=%b -> sum=%h c=%b ovf=%b", i, a, y, cin, sub, s, co, ov);
      checks += 4;
      if (s !== exp_v[W-1:0]) begin errors++; $display("FAIL rnd_sum[%0d] got=%h exp=%h", i, s, exp_v[W-1:0]); end
      if (co !== exp_v[W])    begin errors++; $display("FAIL rnd_cout[%0d] got=%b exp=%b", i, co, exp_v[W]); end
      if (ov !== exp_v[W+1])  begin errors++; $display("FAIL rnd_ovf[%0d] got=%b exp=%b", i, ov, exp_v[W+1]); end
      if (dc != NIBBLES + 1)  begin errors++; $display("FAIL rnd_done_cycle[%0d] got=%0d exp=%0d", i, dc, NIBBLES + 1); end
      model_sum = exp_v[W-1:0];
    end
`ifdef RCA_SERIAL_ACC_EN
    ACC = 1'b0;
`endif
  endtask

  task automatic test_busy_ignore();
    int           dones = 0;
    logic [W-1:0] got = '0;
    @(negedge CLK);
    X = 16'h1234; Y = 16'h0FCC; C_IN = 1'b0; SUB = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    START = 1'b1; X = 16'hAAAA;
    @(negedge CLK);
    START = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      if (DONE) begin dones++; got = SUM; end
    end
    $display("busy_ignore dones=%0d sum=%h", dones, got);
    checks += 2;
    if (dones != 1)        begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    if (got !== 16'h2200)  begin errors++; $display("FAIL ignore_sum got=%h exp=2200", got); end
    model_sum = 16'h2200;
  endtask

  task automatic test_start_held();
    int got_q[$];
    int exp_q[$];
    @(negedge CLK);
    X = 16'h0005; Y = 16'h0007; C_IN = 1'b0; SUB = 1'b0; START = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge CLK);
      if (DONE) begin
        got_q.push_back(c);
        checks++;
        if (SUM !== 16'h000C) begin errors++; $display("FAIL held_sum@%0d got=%h exp=000c", c, SUM); end
      end
      if (c >= NIBBLES + 1 && (c - (NIBBLES + 1)) % (NIBBLES + 2) == 0) exp_q.push_back(c);
    end
    START = 1'b0;
    repeat (10) @(negedge CLK);
    $display("start_held done pulses=%0d expected=%0d", got_q.size(), exp_q.size());
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL held_done_count got=%0d exp=%0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] != exp_q[i]) begin errors++; $display("FAIL held_done_cycle[%0d] got=%0d exp=%0d", i, got_q[i], exp_q[i]); end
      end
    end
    model_sum = 16'h000C;
  endtask

  task automatic test_rst_mid_run();
    int           dones = 0;
    logic [W-1:0] s;
    logic         co, ov;
    int           bc, dc;
    @(negedge CLK);
    X = 16'h1111; Y = 16'h2222; C_IN = 1'b0; SUB = 1'b0; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    $display("rst_mid_run sum=%h c=%b ovf=%b busy=%b done=%b", SUM, C_OUT, OVF, BUSY, DONE);
    checks += 5;
    if (SUM !== '0)     begin errors++; $display("FAIL rst_sum got=%h exp=0", SUM); end
    if (C_OUT !== 1'b0) begin errors++; $display("FAIL rst_cout got=%b exp=0", C_OUT); end
    if (OVF !== 1'b0)   begin errors++; $display("FAIL rst_ovf got=%b exp=0", OVF); end
    if (BUSY !== 1'b0)  begin errors++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
    if (DONE !== 1'b0)  begin errors++; $display("FAIL rst_done got=%b exp=0", DONE); end
    for (int c = 0; c < 8; c++) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    checks++;
    if (dones != 0) begin errors++; $display("FAIL rst_no_done got=%0d exp=0", dones); end
    // RST and START together: reset takes priority, nothing starts.
    RST = 1'b1; START = 1'b1;
    @(negedge CLK);
    RST = 1'b0; START = 1'b0;
    @(negedge CLK);
    checks++;
    if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_start_busy got=%b exp=0", BUSY); end
    model_sum = '0;
    run_op(16'h0001, 16'h0001, 1'b0, 1'b0, s, co, ov, bc, dc);
    $display("after_rst 0001+0001 -> sum=%h c=%b ovf=%b done@%0d", s, co, ov, dc);
    checks += 3;
    if (s !== 16'h0002)    begin errors++; $display("FAIL post_rst_sum got=%h exp=0002", s); end
    if (co !== 1'b0)       begin errors++; $display("FAIL post_rst_cout got=%b exp=0", co); end
    if (dc != NIBBLES + 1) begin errors++; $display("FAIL post_rst_done_cycle got=%0d exp=%0d", dc, NIBBLES + 1); end
    model_sum = 16'h0002;
  endtask

`ifdef RCA_SERIAL_ACC_EN
  task automatic test_acc();
    logic [W-1:0] s;
    logic         co, ov;
    int           bc, dc;
    ACC = 1'b0;
    run_op(16'h0005, 16'h0003, 1'b0, 1'b0, s, co, ov, bc, dc);
    $display("acc0 -> sum=%h", s);
    checks++;
    if (s !== 16'h0008) begin errors++; $display("FAIL acc_load_sum got=%h exp=0008", s); end
    ACC = 1'b1;
    run_op(16'hFFFF, 16'h0010, 1'b0, 1'b0, s, co, ov, bc, dc);
    $display("acc1 add -> sum=%h", s);
    checks++;
    if (s !== 16'h0018) begin errors++; $display("FAIL acc_add_sum got=%h exp=0018", s); end
    run_op(16'hFFFF, 16'h0018, 1'b0, 1'b1, s, co, ov, bc, dc);
    $display("acc1 sub -> sum=%h c=%b", s, co);
    checks += 2;
    if (s !== 16'h0000) begin errors++; $display("FAIL acc_sub_sum got=%h exp=0000", s); end
    if (co !== 1'b1)    begin errors++; $display("FAIL acc_sub_cout got=%b exp=1", co); end
    ACC = 1'b0;
    model_sum = 16'h0000;
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_busy_ignore();
    test_start_held();
    test_rst_mid_run();
`ifdef RCA_SERIAL_ACC_EN
    test_acc();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
